// File: rtl/cbus_pkg.sv
// Shared cbus request/response bundles.
// Burst length codes used by the caches.
package cbus_pkg;

  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants one of NUM_MASTERS cache cbus masters the memory cbus
// for a whole burst (index 0 = ICache, 1 = DCache).
// Ports: clk, reset (sync, active-high); mreq/mresp per master;
// oreq/oresp to the memory side; busy = grant held; owner = granted index.
// Define CBUS_ARB_RR_EN for round-robin selection (default: fixed priority).
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        mreq  [NUM_MASTERS],
  output cbus_resp_t       mresp [NUM_MASTERS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] owner
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] owner_next;
  logic [IDX_W-1:0] win;
  logic             any_valid;
  logic             exit_grant;
  cbus_req_t        own_req;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  int               rr_idx;

  // Walk the ring backwards so the entry nearest rr_ptr is written last.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    rr_idx    = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= NUM_MASTERS) rr_idx = rr_idx - NUM_MASTERS;
      if (mreq[rr_idx].valid) begin
        win       = IDX_W'(rr_idx);
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (exit_grant) begin
      if (int'(owner) == NUM_MASTERS - 1) rr_ptr <= '0;
      else rr_ptr <= owner + 1'b1;
    end
  end
`else
  // Lowest valid index wins.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (mreq[i].valid) begin
        win       = IDX_W'(i);
        any_valid = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    own_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner == IDX_W'(i)) own_req = mreq[i];
    end
  end

  // Abort (owner dropped valid) and ready&last both release the grant.
  assign exit_grant = (state == GRANT) &&
                      (!own_req.valid || (oresp.ready && oresp.last));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    oreq       = '0;
    busy       = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) mresp[i] = '0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          owner_next = win;
          state_next = GRANT;
        end
      end
      GRANT: begin
        busy = 1'b1;
        oreq = own_req;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (owner == IDX_W'(i)) mresp[i] = oresp;
        end
        if (exit_grant) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter (two masters).
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  mreq  [2];
  cbus_resp_t mresp [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [0:0] owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_MASTERS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .mreq  (mreq),
    .mresp (mresp),
    .oreq  (oreq),
    .oresp (oresp),
    .busy  (busy),
    .owner (owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(int m, logic w, logic [31:0] a, logic [3:0] l);
    mreq[m].valid    = 1'b1;
    mreq[m].is_write = w;
    mreq[m].size     = 3'd2;
    mreq[m].addr     = a;
    mreq[m].strobe   = 4'hf;
    mreq[m].data     = 32'h0;
    mreq[m].len      = l;
    mreq[m].burst    = 2'b01;
  endtask

  task automatic beat(logic rdy, logic lst, logic [31:0] d);
    oresp.ready = rdy;
    oresp.last  = lst;
    oresp.data  = d;
  endtask

  int n;
  int first;
  int other;

  initial begin
    reset   = 1'b1;
    mreq[0] = '0;
    mreq[1] = '0;
    oresp   = '0;
    mreq[0].valid = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_oreq", 32'(oreq === '0), 32'd1);
    chk("rst_mresp0", 32'(mresp[0] === '0), 32'd1);
    chk("rst_mresp1", 32'(mresp[1] === '0), 32'd1);
    mreq[0] = '0;
    reset = 1'b0;
    tick();

    // single master m1 read, 16 beats
    req(1, 1'b0, 32'h8000_0080, MLEN16);
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t1_oreq_valid_c0", 32'(oreq.valid), 32'd0);
    tick();
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_owner", 32'(owner), 32'd1);
    chk("t1_oreq_valid_c1", 32'(oreq.valid), 32'd1);
    chk("t1_oreq_addr", oreq.addr, 32'h8000_0080);
    chk("t1_oreq_len", 32'(oreq.len), 32'(MLEN16));
    n = 0;
    for (int b = 0; b < 16; b++) begin
      beat(1'b1, b == 15, 32'h100 + b);
      #1;
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_m1_data", mresp[1].data, 32'h100 + b);
      chk("t1_m1_last", 32'(mresp[1].last), 32'(b == 15));
      chk("t1_m0_zero", 32'(mresp[0] === '0), 32'd1);
      if (mresp[1].ready) n++;
      tick();
    end
    mreq[1] = '0;
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t1_beats", 32'(n), 32'd16);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_oreq_end", 32'(oreq === '0), 32'd1);

    // contention: both request together, m0 wins
    req(0, 1'b0, 32'h8000_1000, MLEN4);
    req(1, 1'b0, 32'h8000_2000, MLEN1);
    tick();
    chk("t2_owner0", 32'(owner), 32'd0);
    chk("t2_oreq_addr", oreq.addr, 32'h8000_1000);
    for (int b = 0; b < 4; b++) begin
      beat(1'b1, b == 3, 32'h200 + b);
      #1;
      chk("t2_m0_ready", 32'(mresp[0].ready), 32'd1);
      chk("t2_m1_zero", 32'(mresp[1] === '0), 32'd1);
      tick();
    end
    mreq[0] = '0;
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t2_bubble_busy", 32'(busy), 32'd0);
    chk("t2_bubble_oreq", 32'(oreq.valid), 32'd0);
    tick();
    chk("t2_owner1", 32'(owner), 32'd1);
    chk("t2_busy1", 32'(busy), 32'd1);
    beat(1'b1, 1'b1, 32'h55);
    #1;
    chk("t2_m1_single", 32'(mresp[1].ready), 32'd1);
    tick();
    mreq[1] = '0;
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t2_end_busy", 32'(busy), 32'd0);

    // m0 served alone, then a second contention
    req(0, 1'b0, 32'h8000_3000, MLEN1);
    tick();
    beat(1'b1, 1'b1, 32'h66);
    #1;
    chk("t3_m0_ready", 32'(mresp[0].ready), 32'd1);
    tick();
    mreq[0] = '0;
    beat(1'b0, 1'b0, 32'h0);
    req(0, 1'b0, 32'h8000_4000, MLEN1);
    req(1, 1'b0, 32'h8000_5000, MLEN1);
`ifdef CBUS_ARB_RR_EN
    first = 1;
`else
    first = 0;
`endif
    other = 1 - first;
    tick();
    chk("t3_first_owner", 32'(owner), 32'(first));
    beat(1'b1, 1'b1, 32'h77);
    #1;
    chk("t3_first_ready", 32'(mresp[first].ready), 32'd1);
    chk("t3_other_zero", 32'(mresp[other].ready), 32'd0);
    tick();
    mreq[first] = '0;
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t3_bubble_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_second_owner", 32'(owner), 32'(other));
    beat(1'b1, 1'b1, 32'h88);
    #1;
    chk("t3_second_ready", 32'(mresp[other].ready), 32'd1);
    tick();
    mreq[0] = '0;
    mreq[1] = '0;
    beat(1'b0, 1'b0, 32'h0);
    tick();

    // backpressure: m1 write, ready toggles, data changes each cycle
    req(1, 1'b1, 32'h8000_0200, MLEN16);
    tick();
    chk("t4_owner", 32'(owner), 32'd1);
    chk("t4_is_write", 32'(oreq.is_write), 32'd1);
    n = 0;
    for (int c = 0; c < 31; c++) begin
      mreq[1].data = 32'hD000 + c;
      beat(c % 2 == 0, (c % 2 == 0) && n == 15, 32'h0);
      #1;
      chk("t4_ready_mirror", 32'(mresp[1].ready), 32'(c % 2 == 0));
      chk("t4_data_live", oreq.data, 32'hD000 + c);
      chk("t4_busy", 32'(busy), 32'd1);
      if (c % 2 == 0) n++;
      tick();
    end
    mreq[1] = '0;
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t4_beats", 32'(n), 32'd16);
    chk("t4_busy_end", 32'(busy), 32'd0);
    tick();

    // back-to-back writeback then fetch from m1
    req(1, 1'b1, 32'h8000_0600, MLEN1);
    tick();
    chk("t5_wb_busy", 32'(busy), 32'd1);
    beat(1'b1, 1'b1, 32'h0);
    #1;
    chk("t5_wb_ready", 32'(mresp[1].ready), 32'd1);
    tick();
    req(1, 1'b0, 32'h8000_0100, MLEN1);
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t5_gap_busy", 32'(busy), 32'd0);
    chk("t5_gap_oreq", 32'(oreq.valid), 32'd0);
    tick();
    chk("t5_fetch_busy", 32'(busy), 32'd1);
    chk("t5_fetch_addr", oreq.addr, 32'h8000_0100);
    chk("t5_fetch_rd", 32'(oreq.is_write), 32'd0);
    beat(1'b1, 1'b1, 32'h99);
    #1;
    chk("t5_fetch_data", mresp[1].data, 32'h99);
    tick();
    mreq[1] = '0;
    beat(1'b0, 1'b0, 32'h0);
    tick();

    // abort: m1 drops valid after beat 5, m0 waiting
    req(1, 1'b0, 32'h8000_0800, MLEN16);
    tick();
    chk("t6_owner1", 32'(owner), 32'd1);
    req(0, 1'b0, 32'h8000_0900, MLEN16);
    for (int b = 0; b < 5; b++) begin
      beat(1'b1, 1'b0, 32'h300 + b);
      #1;
      chk("t6_m1_ready", 32'(mresp[1].ready), 32'd1);
      chk("t6_m0_zero", 32'(mresp[0] === '0), 32'd1);
      tick();
    end
    mreq[1].valid = 1'b0;
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t6_abort_oreq", 32'(oreq.valid), 32'd0);
    tick();
    beat(1'b1, 1'b0, 32'h400);
    #1;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_m1", 32'(mresp[1] === '0), 32'd1);
    chk("t6_idle_oreq", 32'(oreq.valid), 32'd0);
    tick();
    chk("t6_m0_owner", 32'(owner), 32'd0);
    chk("t6_m0_busy", 32'(busy), 32'd1);

    // reset mid-burst at beat 8 of m0
    for (int b = 0; b < 8; b++) begin
      beat(1'b1, 1'b0, 32'h500 + b);
      #1;
      chk("t7_m0_ready", 32'(mresp[0].ready), 32'd1);
      chk("t7_m1_zero", 32'(mresp[1] === '0), 32'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_oreq", 32'(oreq === '0), 32'd1);
    chk("t7_rst_m0", 32'(mresp[0] === '0), 32'd1);
    chk("t7_rst_m1", 32'(mresp[1] === '0), 32'd1);
    reset = 1'b0;
    tick();
    chk("t7_rearb_owner", 32'(owner), 32'd0);
    chk("t7_rearb_busy", 32'(busy), 32'd1);
    beat(1'b1, 1'b1, 32'h600);
    #1;
    chk("t7_rearb_data", mresp[0].data, 32'h600);
    tick();
    mreq[0] = '0;
    beat(1'b0, 1'b0, 32'h0);
    #1;
    chk("t7_end_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
